uart_rx_gen2: RTL and testbench
===============================

UART_RX_GEN2 -- requirements
Module: uart_rx_gen2

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter PRESCALE_W, default 6, width of the prescale input.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 SRL_data  input  1  asynchronous serial line; idle high.
REQ-006 prescale  input  PRESCALE_W  clocks per bit (oversampling ratio).
REQ-007 PAR_EN  input  1  1 = parity bit present.
REQ-008 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 STOP2  input  1  1 = two stop bits expected, 0 = one stop bit.
REQ-010 P_DATA  output  DATA_WIDTH  last good received word; LSB first on the line.
REQ-011 Data_Valid  output  1  one-cycle pulse; P_DATA is new.
REQ-012 parity_err  output  1  one-cycle pulse; parity mismatch.
REQ-013 framing_err  output  1  one-cycle pulse; a stop bit was sampled low.
REQ-014 break_det  output  1  one-cycle pulse; break condition detected.

Function
REQ-015 SRL_data SHALL pass through a 2-FF synchronizer; all decisions use the synchronized value.
REQ-016 Effective ratio: P = max(prescale, 8); H = P>>1 (odd P truncates).
REQ-017 The edge counter SHALL count 0..P-1 within each bit and then wrap to 0, advancing the bit counter.
REQ-018 Each bit value SHALL be the majority of three samples, taken at edge counts H-1, H and H+1; the decision is valid in the cycle after count H+1.
REQ-019 The FSM SHALL have exactly these states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
REQ-020 IDLE -> START when the synchronized line is first seen low; that cycle is edge count 0.
REQ-021 On leaving IDLE, PAR_EN, PAR_TYP, STOP2 and P SHALL be latched; changes to them mid-frame SHALL be ignored.
REQ-022 START: a voted 1 is a false start and SHALL return the FSM to IDLE with no output pulse; a voted 0 SHALL go to DATA at count P-1.
REQ-023 DATA: DATA_WIDTH bits SHALL be shifted in LSB first, then go to PARITY if PAR_EN, else to STOP1.
REQ-024 PARITY: expected bit = XOR(data) ^ PAR_TYP.
REQ-025 STOP1: if STOP2 is latched, go to STOP2 at count P-1.
REQ-026 The frame SHALL resolve at the last stop bit's vote: the FSM returns to IDLE in the cycle after count H+1, without waiting for the end of the bit, so back-to-back frames are accepted.
REQ-027 Resolution for a good frame: P_DATA updates and Data_Valid pulses in the same cycle.
REQ-028 Resolution for a parity error only: parity_err pulses; P_DATA and Data_Valid are unchanged/low.
REQ-029 Resolution for a stop bit voted 0: framing_err pulses; P_DATA is not updated; Data_Valid stays low.
REQ-030 Framing error takes precedence over parity: parity_err SHALL also pulse if parity mismatched.
REQ-031 In two-stop mode, a low first stop bit SHALL resolve immediately as a framing error; STOP2 is not entered.
REQ-032 Break: all data bits 0, parity bit 0 if enabled, and stop voted 0 SHALL pulse break_det with framing_err, then enter WAIT_HIGH.
REQ-033 WAIT_HIGH SHALL hold until the synchronized line is high, then go to IDLE.
REQ-034 At most one frame resolution SHALL occur per frame; the pulses never exceed one cycle.

Reset
REQ-035 While rst=1 at a clock edge: FSM=IDLE, counters=0, synchronizer=1, P_DATA=0, all pulse outputs=0.
REQ-036 Reset asserted mid-frame SHALL abort the frame with no output pulse; reception resumes with the next falling edge after release.

Verification
REQ-037 prescale=8, 8N1, byte 0xA5 -> Data_Valid pulses once; P_DATA=0xA5; no error pulses.
REQ-038 prescale=16, PAR_EN=1, PAR_TYP=0, 0x03 with parity bit 1 -> parity_err pulse; P_DATA retains the prior value; Data_Valid=0.
REQ-039 Low glitch of 3 clocks at prescale=16 -> no pulses; FSM back in IDLE.
REQ-040 STOP2=1, 0x5A, second stop bit low -> framing_err pulse only; a following good 0x3C frame sent with no idle gap -> Data_Valid, P_DATA=0x3C.
REQ-041 Line held low for 2 frame times -> single break_det + framing_err pulse; no reception until the line returns high, then 0x81 is received correctly.
REQ-042 rst pulsed during data bit 4 of a frame -> outputs reset to 0; no pulse for the aborted frame; the next frame 0x11 is received.

Source files
------------

// File: rtl/uart_rx_gen2.sv
// uart_rx_gen2: oversampling UART receiver with 2-FF input synchronizer,
// 3-sample majority vote, optional parity, one or two stop bits and break detection.
`timescale 1ns/1ps
module uart_rx_gen2 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SRL_data,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  parity_err,
    output logic                  framing_err,
    output logic                  break_det
);

    // Counter must hold at least the minimum ratio of 8.
    localparam int unsigned CW = (PRESCALE_W > 4) ? PRESCALE_W : 4;
    localparam int unsigned BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2,
        StWaitHigh
    } state_e;

    state_e                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_prev;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_p;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_samp0;
    logic                  r_samp1;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_stop2;
    logic                  r_par_bit;
    logic                  r_dv;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_brk;

    logic                  w_rx;
    logic [CW-1:0]         w_pre_ext;
    logic [CW-1:0]         w_p;
    logic [CW-1:0]         w_h;
    logic                  w_last;
    logic                  w_at_s0;
    logic                  w_at_s1;
    logic                  w_at_vote;
    logic                  w_vote;
    logic                  w_mismatch;
    logic                  w_break;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= SRL_data;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rx      = r_sync2;
    assign w_pre_ext = CW'(prescale);
    assign w_p       = (w_pre_ext < CW'(8)) ? CW'(8) : w_pre_ext;
    assign w_h       = r_p >> 1;
    assign w_last    = (r_cnt == r_p - CW'(1));
    assign w_at_s0   = (r_cnt == w_h - CW'(1));
    assign w_at_s1   = (r_cnt == w_h);
    // Third sample is the live line value; the decision lands in the next cycle.
    assign w_at_vote = (r_cnt == w_h + CW'(1));
    assign w_vote    = (r_samp0 & r_samp1) | (r_samp0 & w_rx) | (r_samp1 & w_rx);

    assign w_mismatch = r_par_en & (r_par_bit ^ (^r_shift) ^ r_par_typ);
    assign w_break    = (r_shift == '0) & ~(r_par_en & r_par_bit);

    // Frame FSM: bit timing, sampling, shifting and registered result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_p       <= CW'(8);
            r_bit     <= '0;
            r_shift   <= '0;
            r_p_data  <= '0;
            r_samp0   <= 1'b1;
            r_samp1   <= 1'b1;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_stop2   <= 1'b0;
            r_par_bit <= 1'b0;
            r_dv      <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_brk     <= 1'b0;
        end else begin
            r_dv   <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_brk  <= 1'b0;

            if (r_state != StIdle && r_state != StWaitHigh) begin
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                if (w_at_s0) r_samp0 <= w_rx;
                if (w_at_s1) r_samp1 <= w_rx;
            end

            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    // The cycle the low level first appears counts as 0.
                    if (r_prev && !w_rx) begin
                        r_state   <= StStart;
                        r_cnt     <= CW'(1);
                        r_bit     <= '0;
                        r_p       <= w_p;
                        r_par_en  <= PAR_EN;
                        r_par_typ <= PAR_TYP;
                        r_stop2   <= STOP2;
                    end
                end
                StStart: begin
                    if (w_at_vote && w_vote) begin
                        r_state <= StIdle;
                    end else if (w_last) begin
                        r_state <= StData;
                    end
                end
                StData: begin
                    if (w_at_vote) r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
                    if (w_last) begin
                        if (r_bit == BW'(DATA_WIDTH - 1)) begin
                            r_bit   <= '0;
                            r_state <= r_par_en ? StParity : StStop1;
                        end else begin
                            r_bit <= r_bit + BW'(1);
                        end
                    end
                end
                StParity: begin
                    if (w_at_vote) r_par_bit <= w_vote;
                    if (w_last) r_state <= StStop1;
                end
                StStop1: begin
                    if (w_at_vote) begin
                        if (!w_vote) begin
                            r_ferr  <= 1'b1;
                            r_perr  <= w_mismatch;
                            r_brk   <= w_break;
                            r_state <= w_break ? StWaitHigh : StIdle;
                        end else if (!r_stop2) begin
                            r_state <= StIdle;
                            if (w_mismatch) begin
                                r_perr <= 1'b1;
                            end else begin
                                r_dv     <= 1'b1;
                                r_p_data <= r_shift;
                            end
                        end
                    end else if (w_last) begin
                        r_state <= StStop2;
                    end
                end
                StStop2: begin
                    // Line rose for stop 1, so a low here is never a break.
                    if (w_at_vote) begin
                        r_state <= StIdle;
                        if (!w_vote) begin
                            r_ferr <= 1'b1;
                            r_perr <= w_mismatch;
                        end else if (w_mismatch) begin
                            r_perr <= 1'b1;
                        end else begin
                            r_dv     <= 1'b1;
                            r_p_data <= r_shift;
                        end
                    end
                end
                StWaitHigh: begin
                    if (w_rx) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign P_DATA      = r_p_data;
    assign Data_Valid  = r_dv;
    assign parity_err  = r_perr;
    assign framing_err = r_ferr;
    assign break_det   = r_brk;

endmodule

// File: tb/tb_uart_rx_gen2.sv
// Self-checking bench for uart_rx_gen2: directed scenarios plus randomized frames
// checked against a rule-level frame outcome model.
`timescale 1ns/1ps
module tb_uart_rx_gen2;

    logic       clk = 1'b0;
    logic       rst;
    logic       SRL_data;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP2;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       parity_err;
    logic       framing_err;
    logic       break_det;

    int n_vec = 0;
    int n_err = 0;
    int cnt_dv = 0, cnt_pe = 0, cnt_fe = 0, cnt_bk = 0;
    int b_dv, b_pe, b_fe, b_bk;
    logic [7:0]  exp_pdata;
    logic [39:0] obs, exp_b;

    uart_rx_gen2 #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .SRL_data   (SRL_data),
        .prescale   (prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .parity_err (parity_err),
        .framing_err(framing_err),
        .break_det  (break_det)
    );

    always #5 clk = ~clk;

    // Count cycles each pulse is high; a stretched pulse shows up as a count above 1.
    always @(negedge clk) begin
        if (Data_Valid)  cnt_dv <= cnt_dv + 1;
        if (parity_err)  cnt_pe <= cnt_pe + 1;
        if (framing_err) cnt_fe <= cnt_fe + 1;
        if (break_det)   cnt_bk <= cnt_bk + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Bundle layout: {dv cycles, parity cycles, framing cycles, break cycles, P_DATA}.
    function automatic logic [39:0] observed();
        return {8'(cnt_dv - b_dv), 8'(cnt_pe - b_pe), 8'(cnt_fe - b_fe), 8'(cnt_bk - b_bk),
                P_DATA};
    endfunction

    // Expected outcome of one frame from its line-level bit values.
    function automatic logic [39:0] model(input logic [7:0] d, input logic pen, input logic ptyp,
                                          input logic st2, input logic pbit, input logic s1,
                                          input logic s2, input logic [7:0] prev);
        logic perr, ferr, brk, good;
        perr = pen && (pbit != ((^d) ^ ptyp));
        ferr = !s1 || (st2 && !s2);
        brk  = !s1 && (d == 8'h00) && (!pen || !pbit);
        good = !ferr && !perr;
        return {8'(good), 8'(perr), 8'(ferr), 8'(brk), good ? d : prev};
    endfunction

    function automatic int eff_p(input int pre);
        return (pre < 8) ? 8 : pre;
    endfunction

    task automatic snap();
        b_dv = cnt_dv;
        b_pe = cnt_pe;
        b_fe = cnt_fe;
        b_bk = cnt_bk;
    endtask

    task automatic drive_bit(input logic v, input int clks);
        SRL_data = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int pre, input logic pen,
                              input logic ptyp, input logic st2, input logic pbit,
                              input logic s1, input logic s2, input logic scramble);
        int p;
        p = eff_p(pre);
        prescale = 6'(pre);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        STOP2    = st2;
        drive_bit(1'b0, p);
        if (scramble) begin
            prescale = 6'($urandom);
            PAR_EN   = 1'($urandom);
            PAR_TYP  = 1'($urandom);
            STOP2    = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(s1, p);
        if (st2) drive_bit(s2, p);
        SRL_data = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        SRL_data = 1'b1;
        prescale = 6'd8;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        STOP2 = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++;
        if ({P_DATA, Data_Valid, parity_err, framing_err, break_det} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_state: got %h want 000",
                     {P_DATA, Data_Valid, parity_err, framing_err, break_det});
        end
        snap();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        exp_pdata = 8'h00;
        obs = observed();
        n_vec++;
        if (obs !== 40'h0) begin
            n_err++;
            $display("FAIL reset_idle: got %h want %h", obs, 40'h0);
        end
    endtask

    task automatic test_basic_8n1();
        snap();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 16);
        obs = observed();
        exp_b = {8'd1, 8'd0, 8'd0, 8'd0, 8'hA5};
        n_vec++;
        if (obs !== exp_b) begin
            n_err++;
            $display("FAIL basic_8n1: got %h want %h", obs, exp_b);
        end
        exp_pdata = 8'hA5;
    endtask

    task automatic test_parity_err();
        // 0xC4 has three ones, so even parity needs a 1.
        snap();
        send_frame(8'hC4, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 32);
        obs = observed();
        exp_b = {8'd1, 8'd0, 8'd0, 8'd0, 8'hC4};
        n_vec++;
        if (obs !== exp_b) begin
            n_err++;
            $display("FAIL parity_good: got %h want %h", obs, exp_b);
        end
        snap();
        send_frame(8'h03, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 32);
        obs = observed();
        exp_b = {8'd0, 8'd1, 8'd0, 8'd0, 8'hC4};
        n_vec++;
        if (obs !== exp_b) begin
            n_err++;
            $display("FAIL parity_err: got %h want %h", obs, exp_b);
        end
        exp_pdata = 8'hC4;
    endtask

    task automatic test_glitch();
        prescale = 6'd16;
        PAR_EN = 1'b0;
        STOP2 = 1'b0;
        snap();
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 16);
        obs = observed();
        exp_b = {8'd0, 8'd0, 8'd0, 8'd0, exp_pdata};
        n_vec++;
        if (obs !== exp_b) begin
            n_err++;
            $display("FAIL glitch_quiet: got %h want %h", obs, exp_b);
        end
        snap();
        send_frame(8'h6E, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 32);
        obs = observed();
        exp_b = {8'd1, 8'd0, 8'd0, 8'd0, 8'h6E};
        n_vec++;
        if (obs !== exp_b) begin
            n_err++;
            $display("FAIL glitch_recover: got %h want %h", obs, exp_b);
        end
        exp_pdata = 8'h6E;
    endtask

    task automatic test_back_to_back();
        int p;
        logic [7:0] d;
        p = 12;
        d = 8'h5A;
        prescale = 6'(p);
        PAR_EN = 1'b0;
        STOP2 = 1'b1;
        snap();
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        drive_bit(1'b1, p);
        // Second stop pulled low across its sampling window, high again before the next start.
        drive_bit(1'b0, p - p / 4);
        drive_bit(1'b1, p / 4);
        obs = observed();
        exp_b = {8'd0, 8'd0, 8'd1, 8'd0, exp_pdata};
        n_vec++;
        if (obs !== exp_b) begin
            n_err++;
            $display("FAIL stop2_framing: got %h want %h", obs, exp_b);
        end
        snap();
        send_frame(8'h3C, p, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 2 * p);
        obs = observed();
        exp_b = {8'd1, 8'd0, 8'd0, 8'd0, 8'h3C};
        n_vec++;
        if (obs !== exp_b) begin
            n_err++;
            $display("FAIL back_to_back: got %h want %h", obs, exp_b);
        end
        exp_pdata = 8'h3C;
    endtask

    task automatic test_break();
        prescale = 6'd8;
        PAR_EN = 1'b0;
        STOP2 = 1'b0;
        snap();
        drive_bit(1'b0, 2 * 10 * 8);
        obs = observed();
        exp_b = {8'd0, 8'd0, 8'd1, 8'd1, exp_pdata};
        n_vec++;
        if (obs !== exp_b) begin
            n_err++;
            $display("FAIL break_pulse: got %h want %h", obs, exp_b);
        end
        drive_bit(1'b1, 24);
        snap();
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 16);
        obs = observed();
        exp_b = {8'd1, 8'd0, 8'd0, 8'd0, 8'h81};
        n_vec++;
        if (obs !== exp_b) begin
            n_err++;
            $display("FAIL break_recover: got %h want %h", obs, exp_b);
        end
        exp_pdata = 8'h81;
    endtask

    task automatic test_reset_midframe();
        int p;
        logic [7:0] d;
        p = 10;
        // Bits 4..7 high so the line has no falling edge after reset release.
        d = {4'hF, 4'($urandom)};
        prescale = 6'(p);
        PAR_EN = 1'b0;
        STOP2 = 1'b0;
        snap();
        drive_bit(1'b0, p);
        for (int i = 0; i < 4; i++) drive_bit(d[i], p);
        drive_bit(d[4], p / 2);
        rst = 1'b1;
        drive_bit(d[4], 2);
        rst = 1'b0;
        drive_bit(d[4], p - p / 2 - 2);
        for (int i = 5; i < 8; i++) drive_bit(d[i], p);
        drive_bit(1'b1, p);
        drive_bit(1'b1, 2 * p);
        obs = observed();
        exp_b = {8'd0, 8'd0, 8'd0, 8'd0, 8'h00};
        n_vec++;
        if (obs !== exp_b) begin
            n_err++;
            $display("FAIL reset_abort: got %h want %h", obs, exp_b);
        end
        snap();
        send_frame(8'h11, p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 2 * p);
        obs = observed();
        exp_b = {8'd1, 8'd0, 8'd0, 8'd0, 8'h11};
        n_vec++;
        if (obs !== exp_b) begin
            n_err++;
            $display("FAIL reset_resume: got %h want %h", obs, exp_b);
        end
        exp_pdata = 8'h11;
    endtask

    task automatic test_random();
        int pre;
        logic [7:0] d;
        logic pen, ptyp, st2, pbit, s1, s2, scr;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0: pre = 5;
                1: pre = 8;
                2: pre = 9;
                3: pre = 11;
                4: pre = 16;
                default: pre = 23;
            endcase
            d    = 8'($urandom);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            st2  = 1'($urandom);
            scr  = 1'($urandom);
            pbit = (^d) ^ ptyp;
            s1   = 1'b1;
            s2   = 1'b1;
            case ($urandom_range(0, 7))
                0: pbit = ~pbit;
                1: s1 = 1'b0;
                2: s2 = 1'b0;
                3: begin
                    d = 8'h00;
                    pbit = 1'b0;
                    s1 = 1'b0;
                    s2 = 1'b0;
                end
                default: ;
            endcase
            exp_b = model(d, pen, ptyp, st2, pbit, s1, s2, exp_pdata);
            snap();
            send_frame(d, pre, pen, ptyp, st2, pbit, s1, s2, scr);
            drive_bit(1'b1, 2 * eff_p(pre));
            obs = observed();
            n_vec++;
            if (obs !== exp_b) begin
                n_err++;
                $display("FAIL random_%0d (d=%h pre=%0d pen=%b typ=%b st2=%b): got %h want %h",
                         k, d, pre, pen, ptyp, st2, obs, exp_b);
            end
            exp_pdata = exp_b[7:0];
        end
    endtask

    initial begin
        rst = 1'b1;
        SRL_data = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_8n1();
        test_parity_err();
        test_glitch();
        test_back_to_back();
        test_break();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
